ifid_fetch_queue: RTL and testbench
===================================

Name: ifid_fetch_queue

Overview:
- Parametrised successor to the single-entry IF/ID pipeline register. It sits between the fetch stage (instruction, next PC, cache hit) and decode.
- Buffers up to DEPTH fetched instructions in a FIFO so that decode stalls no longer freeze fetch immediately.
- Adds branch/jump flush, hit-gated writes, and a saturating instruction-cache miss counter.

Parameters:
- DATA_W, 32, instruction word width.
- PC_W, 32, next-PC width.
- DEPTH, 4, number of entries; power of two, 2..16.
- CNT_W, 16, width of the miss counter.

Ports:
- clk, input, 1, rising-edge clock.
- reset, input, 1, synchronous active-high reset.
- in_valid, input, 1, fetch presents an instruction this cycle.
- in_hit, input, 1, instruction cache hit for the presented instruction.
- in_instr, input, DATA_W, fetched instruction.
- in_next_pc, input, PC_W, PC+4 of the fetched instruction.
- in_ready, output, 1, queue can accept an entry.
- flush, input, 1, branch/jump taken: discard all entries.
- out_ready, input, 1, decode accepts the head entry (not stalled).
- out_valid, output, 1, head entry is valid.
- out_instr, output, DATA_W, head instruction; 0 (NOP) when empty.
- out_next_pc, output, PC_W, head next-PC; 0 when empty.
- count, output, $clog2(DEPTH)+1, current occupancy.
- miss_cnt, output, CNT_W, saturating count of miss cycles.

Behaviour:
- Storage is DEPTH entries of {instr, next_pc}, with read pointer rd_ptr and write pointer wr_ptr, each $clog2(DEPTH) bits and wrapping modulo DEPTH, plus a registered count.
- Reset (synchronous, highest priority):
  - rd_ptr=0, wr_ptr=0, count=0, miss_cnt=0.
  - Storage contents are don't-care.
  - Resulting outputs: out_valid=0, out_instr=0, out_next_pc=0, in_ready=1.
  - Reset mid-operation discards all entries and ignores push, pop and flush in that cycle.
- in_ready = (count != DEPTH). It is registered-state only, with no combinational path from out_ready.
- Push condition: push = in_valid & in_hit & in_ready & ~flush.
  - A miss (in_valid & ~in_hit) never writes; fetch re-presents the instruction later.
  - A push writes the entry at wr_ptr, and wr_ptr increments.
- Pop condition: pop = out_valid & out_ready & ~flush. A pop increments rd_ptr.
- out_valid = (count != 0).
- out_instr and out_next_pc are the head entry when out_valid=1, otherwise forced to 0.
- Latency: an entry pushed at edge N is visible at the outputs after edge N, i.e. one cycle from input to decode when the queue is empty. There is no combinational bypass.
- Count update:
  - push & ~pop: +1.
  - pop & ~push: -1.
  - push & pop: unchanged, with both pointers advancing. This is legal when 0 < count < DEPTH.
- Full: in_ready=0, so no push even if a pop occurs in the same cycle. The slot frees on the next cycle.
- Empty: pop is impossible because out_valid=0, and out_ready is ignored.
- Flush (when not in reset):
  - Next state is rd_ptr=wr_ptr=0, count=0.
  - Any simultaneous in_valid entry is dropped and any simultaneous pop is suppressed.
  - out_valid=0 on the following cycle.
  - miss_cnt is unaffected by flush.
- miss_cnt:
  - Increments on every cycle with in_valid & ~in_hit & ~reset, including flush cycles.
  - Saturates at 2^CNT_W-1 and never wraps.
- Pointer wrap: when an index goes DEPTH-1 to 0, it must preserve FIFO order across the wrap.
- No X may propagate to the outputs after reset, even though storage is uninitialised.

Test Plan:
- Reset, then idle -> out_valid=0, out_instr=0, in_ready=1, count=0, miss_cnt=0.
- With out_ready=0, push 32'h8C010004 (next_pc 4), then 32'h00221820 (next_pc 8):
  - One cycle after the first push: out_valid=1, out_instr=32'h8C010004.
  - After both pushes: count=2.
  - Then set out_ready=1: the two entries are delivered in order, and out_valid=0 afterwards.
- With DEPTH=4 and out_ready=0, push 5 entries -> in_ready=0 after the 4th, the 5th is not written, and count=4.
  - Then drain with out_ready=1 -> entries 1..4 exit in order.
- Continuous push and pop for 10 entries (next_pc 4..40) with out_ready=1 -> count stays at 1, and the output sequence matches the input across pointer wrap.
- With count=3, assert flush together with in_valid=1, in_hit=1 and out_ready=1 -> next cycle count=0, out_valid=0, nothing popped or pushed; the next push is delivered as the head.
- Hold in_valid=1, in_hit=0 for 5 cycles -> miss_cnt=5 and count unchanged. With CNT_W=3, 10 miss cycles -> miss_cnt=7 (saturated). Asserting reset mid-stream -> miss_cnt=0 and count=0 the next cycle.

Source files
------------

// File: rtl/ifid_fetch_queue.sv
// IF/ID fetch queue: a DEPTH-entry FIFO of {instr, next_pc} between fetch and decode.
// Supports flush on a taken branch, writes gated by a cache hit, and a saturating miss counter.
module ifid_fetch_queue #(
   parameter int DATA_W = 32,
   parameter int PC_W   = 32,
   parameter int DEPTH  = 4,
   parameter int CNT_W  = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_valid,
   input  logic                     in_hit,
   input  logic [DATA_W-1:0]        in_instr,
   input  logic [PC_W-1:0]          in_next_pc,
   output logic                     in_ready,
   input  logic                     flush,
   input  logic                     out_ready,
   output logic                     out_valid,
   output logic [DATA_W-1:0]        out_instr,
   output logic [PC_W-1:0]          out_next_pc,
   output logic [$clog2(DEPTH):0]   count,
   output logic [CNT_W-1:0]         miss_cnt
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [AW-1:0]     r_rd_ptr;
   logic [AW-1:0]     r_wr_ptr;
   logic [AW:0]       r_count;
   logic [CNT_W-1:0]  r_miss_cnt;
   logic [DATA_W-1:0] r_instr_mem [DEPTH];
   logic [PC_W-1:0]   r_pc_mem    [DEPTH];

   logic w_in_ready;
   logic w_out_valid;
   logic w_push;
   logic w_pop;
   logic w_miss;

   // Handshake signals derive only from registered occupancy, never from out_ready.
   assign w_in_ready  = (r_count != FULL_CNT);
   assign w_out_valid = (r_count != '0);
   assign w_push      = in_valid & in_hit & w_in_ready & ~flush & ~reset;
   assign w_pop       = w_out_valid & out_ready & ~flush;
   assign w_miss      = in_valid & ~in_hit;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else if (flush) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + (AW+1)'(1);
            2'b01:   r_count <= r_count - (AW+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage is never reset; the output gating below keeps stale contents invisible.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_instr_mem[r_wr_ptr] <= in_instr;
         r_pc_mem[r_wr_ptr]    <= in_next_pc;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_miss_cnt <= '0;
      end else if (w_miss && !(&r_miss_cnt)) begin
         r_miss_cnt <= r_miss_cnt + CNT_W'(1);
      end
   end

   assign in_ready    = w_in_ready;
   assign out_valid   = w_out_valid;
   assign out_instr   = w_out_valid ? r_instr_mem[r_rd_ptr] : '0;
   assign out_next_pc = w_out_valid ? r_pc_mem[r_rd_ptr]    : '0;
   assign count       = r_count;
   assign miss_cnt    = r_miss_cnt;

endmodule

// File: tb/tb_ifid_fetch_queue.sv
// Testbench for ifid_fetch_queue: a queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations. A second instance uses a 3-bit miss counter.
module tb_ifid_fetch_queue;

   logic        clk = 1'b0;
   logic        reset, in_valid, in_hit, flush, out_ready;
   logic [31:0] in_instr, in_next_pc;

   logic        in_ready, out_valid;
   logic [31:0] out_instr, out_next_pc;
   logic [2:0]  count;
   logic [15:0] miss_cnt;

   logic        in_ready_s, out_valid_s;
   logic [31:0] out_instr_s, out_next_pc_s;
   logic [2:0]  count_s;
   logic [2:0]  miss_cnt_s;

   int n_pass  = 0;
   int n_total = 0;
   bit cmp_en  = 1'b0;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
   } ent_t;
   ent_t m_q[$];
   int   m_miss   = 0;
   int   m_miss_s = 0;

   always #5 clk = ~clk;

   ifid_fetch_queue #(.DATA_W(32), .PC_W(32), .DEPTH(4), .CNT_W(16)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_hit(in_hit),
      .in_instr(in_instr), .in_next_pc(in_next_pc), .in_ready(in_ready),
      .flush(flush), .out_ready(out_ready), .out_valid(out_valid),
      .out_instr(out_instr), .out_next_pc(out_next_pc), .count(count),
      .miss_cnt(miss_cnt)
   );

   ifid_fetch_queue #(.DATA_W(32), .PC_W(32), .DEPTH(4), .CNT_W(3)) dut_s (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_hit(in_hit),
      .in_instr(in_instr), .in_next_pc(in_next_pc), .in_ready(in_ready_s),
      .flush(flush), .out_ready(out_ready), .out_valid(out_valid_s),
      .out_instr(out_instr_s), .out_next_pc(out_next_pc_s), .count(count_s),
      .miss_cnt(miss_cnt_s)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   // Reference model: FIFO rules stated directly on a queue.
   initial begin
      forever begin
         @(posedge clk);
         if (reset) begin
            m_q.delete();
            m_miss   = 0;
            m_miss_s = 0;
         end else begin
            if (in_valid && !in_hit) begin
               if (m_miss < 65535) m_miss++;
               if (m_miss_s < 7) m_miss_s++;
            end
            if (flush) begin
               m_q.delete();
            end else begin
               bit do_pop, do_push;
               do_pop  = (m_q.size() != 0) && out_ready;
               do_push = in_valid && in_hit && (m_q.size() < 4);
               if (do_pop) void'(m_q.pop_front());
               if (do_push) m_q.push_back('{in_instr, in_next_pc});
            end
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (cmp_en) begin
            logic [31:0] e_instr, e_pc;
            e_instr = (m_q.size() != 0) ? m_q[0].instr : 32'h0;
            e_pc    = (m_q.size() != 0) ? m_q[0].pc    : 32'h0;
            chk("out_valid",   64'(out_valid),   64'(m_q.size() != 0));
            chk("out_instr",   64'(out_instr),   64'(e_instr));
            chk("out_next_pc", 64'(out_next_pc), 64'(e_pc));
            chk("in_ready",    64'(in_ready),    64'(m_q.size() != 4));
            chk("count",       64'(count),       64'(m_q.size()));
            chk("miss_cnt",    64'(miss_cnt),    64'(m_miss));
            chk("s_count",     64'(count_s),     64'(m_q.size()));
            chk("s_out_instr", 64'(out_instr_s), 64'(e_instr));
            chk("s_miss_cnt",  64'(miss_cnt_s),  64'(m_miss_s));
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic cyc(input logic iv, input logic hit, input logic [31:0] ins,
                      input logic [31:0] pc, input logic fl, input logic ordy);
      in_valid   = iv;
      in_hit     = hit;
      in_instr   = ins;
      in_next_pc = pc;
      flush      = fl;
      out_ready  = ordy;
      step();
   endtask

   initial begin
      reset = 1'b1; in_valid = 1'b0; in_hit = 1'b0; flush = 1'b0; out_ready = 1'b0;
      in_instr = '0; in_next_pc = '0;
      step();
      step();
      reset  = 1'b0;
      cmp_en = 1'b1;

      // Reset then idle
      cyc(0, 0, 0, 0, 0, 0);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_instr", 64'(out_instr), 64'd0);
      chk("rst_in_ready",  64'(in_ready),  64'd1);
      chk("rst_count",     64'(count),     64'd0);
      chk("rst_miss",      64'(miss_cnt),  64'd0);

      // Two pushes with decode stalled, then delivery in order
      cyc(1, 1, 32'h8C010004, 32'd4, 0, 0);
      chk("p1_valid", 64'(out_valid), 64'd1);
      chk("p1_instr", 64'(out_instr), 64'h8C010004);
      cyc(1, 1, 32'h00221820, 32'd8, 0, 0);
      chk("p2_count", 64'(count), 64'd2);
      chk("p2_head",  64'(out_instr), 64'h8C010004);
      cyc(0, 0, 0, 0, 0, 1);
      chk("d1_instr", 64'(out_instr), 64'h00221820);
      chk("d1_pc",    64'(out_next_pc), 64'd8);
      cyc(0, 0, 0, 0, 0, 1);
      chk("d2_valid", 64'(out_valid), 64'd0);

      // Fill past full, then drain
      for (int i = 1; i <= 5; i++) begin
         cyc(1, 1, 32'hA0 + 32'(i), 32'(4 * i), 0, 0);
         if (i == 4) chk("full_in_ready", 64'(in_ready), 64'd0);
      end
      chk("full_count", 64'(count), 64'd4);
      for (int i = 1; i <= 4; i++) begin
         chk("drain_instr", 64'(out_instr), 64'hA0 + 64'(i));
         cyc(0, 0, 0, 0, 0, 1);
      end
      chk("drain_empty", 64'(out_valid), 64'd0);

      // Streaming across pointer wrap
      for (int i = 1; i <= 10; i++) begin
         cyc(1, 1, 32'hC000 + 32'(i), 32'(4 * i), 0, 1);
         chk("stream_count", 64'(count), 64'd1);
         chk("stream_pc",    64'(out_next_pc), 64'(4 * i));
      end
      cyc(0, 0, 0, 0, 0, 1);
      chk("stream_empty", 64'(out_valid), 64'd0);

      // Flush with simultaneous push and pop
      for (int i = 1; i <= 3; i++) cyc(1, 1, 32'hD0 + 32'(i), 32'(i), 0, 0);
      chk("pre_flush_count", 64'(count), 64'd3);
      cyc(1, 1, 32'hDEAD, 32'h99, 1, 1);
      chk("flush_count", 64'(count), 64'd0);
      chk("flush_valid", 64'(out_valid), 64'd0);
      cyc(1, 1, 32'hBEEF, 32'h40, 0, 0);
      chk("post_flush_head", 64'(out_instr), 64'hBEEF);
      chk("post_flush_count", 64'(count), 64'd1);

      // Miss cycles never write; narrow counter saturates
      for (int i = 0; i < 5; i++) cyc(1, 0, 32'hEEEE, 32'h0, 0, 0);
      chk("miss5", 64'(miss_cnt), 64'd5);
      chk("miss5_count", 64'(count), 64'd1);
      for (int i = 0; i < 5; i++) cyc(1, 0, 32'hEEEE, 32'h0, 0, 0);
      chk("miss10", 64'(miss_cnt), 64'd10);
      chk("miss_sat", 64'(miss_cnt_s), 64'd7);
      cyc(1, 0, 32'hEEEE, 32'h0, 1, 0);
      chk("miss_flush", 64'(miss_cnt), 64'd11);

      // Reset mid-stream
      cyc(1, 1, 32'hF00D, 32'h44, 0, 0);
      reset = 1'b1;
      cyc(1, 0, 32'hEEEE, 32'h0, 0, 1);
      reset = 1'b0;
      chk("mid_rst_miss",   64'(miss_cnt),   64'd0);
      chk("mid_rst_miss_s", 64'(miss_cnt_s), 64'd0);
      chk("mid_rst_count",  64'(count),      64'd0);
      cyc(0, 0, 0, 0, 0, 0);
      chk("final_valid", 64'(out_valid), 64'd0);

      cmp_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
